// File: rtl/pll_pkg.sv
// Shared types and sizing helpers for the shift-controlled oscillator.
package pll_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } osc_state_t;

    localparam int DIV_N_DEFAULT     = 32;
    localparam int PENDING_W_DEFAULT = 3;

    function automatic int phase_w(input int div_n);
        return $clog2(div_n);
    endfunction

    // Symmetric limit: the most negative two's-complement code is never used.
    function automatic int pend_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pending_accumulator.sv
// Saturating signed count of corrections requested but not yet applied.
module pending_accumulator
    import pll_pkg::*;
#(
    parameter int PENDING_W = PENDING_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [1:0]           delta,
    input  logic signed [1:0]           consume,
    output logic signed [PENDING_W-1:0] pending,
    output logic                        overflow
);

    localparam logic signed [PENDING_W:0] LIMIT = (PENDING_W + 1)'(pend_max(PENDING_W));

    logic signed [PENDING_W:0] base;
    logic signed [PENDING_W:0] cand;
    logic                      drop;

    // Consuming always moves toward zero, so only the new request can overflow.
    always_comb begin
        base = {pending[PENDING_W-1], pending} - {{(PENDING_W-1){consume[1]}}, consume};
        cand = base + {{(PENDING_W-1){delta[1]}}, delta};
        drop = (cand > LIMIT) || (cand < -LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= drop ? base[PENDING_W-1:0] : cand[PENDING_W-1:0];
            overflow <= drop;
        end
    end

endmodule

// File: rtl/shift_controlled_oscillator.sv
// Divide-by-DIV_N oscillator whose wrap point slips one count per period to apply queued shifts.
module shift_controlled_oscillator
    import pll_pkg::*;
#(
    parameter int DIV_N     = DIV_N_DEFAULT,
    parameter int PENDING_W = PENDING_W_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       positiveShift_i,
    input  logic                       negativeShift_i,
    output logic [phase_w(DIV_N)-1:0]  phase_o,
    output logic                       recoveredClk_o,
    output logic                       strobe_o,
    output logic                       correctionApplied_o,
    output logic                       overflow_o
);

    localparam int PHASE_W = phase_w(DIV_N);
    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(DIV_N - 1);
    localparam logic [PHASE_W-1:0] MID  = PHASE_W'(DIV_N / 2);

    osc_state_t                  state;
    logic signed [1:0]           delta;
    logic signed [1:0]           consume;
    logic signed [PENDING_W-1:0] pending;
    logic                        wrap;

    always_comb begin
        delta = 2'sd0;
        if (positiveShift_i && !negativeShift_i)
            delta = 2'sd1;
        else if (negativeShift_i && !positiveShift_i)
            delta = -2'sd1;
    end

    // The decision uses the registered pending value; a same-cycle request waits a period.
    always_comb begin
        wrap    = (state == RUN) && (phase_o == LAST);
        consume = 2'sd0;
        if (wrap) begin
            if (pending[PENDING_W-1])
                consume = -2'sd1;
            else if (pending != '0)
                consume = 2'sd1;
        end
    end

    pending_accumulator #(
        .PENDING_W (PENDING_W)
    ) u_pending (
        .clk      (clk_i),
        .reset    (reset_i),
        .delta    (delta),
        .consume  (consume),
        .pending  (pending),
        .overflow (overflow_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            phase_o             <= '0;
            state               <= RUN;
            correctionApplied_o <= 1'b0;
        end else begin
            correctionApplied_o <= (consume != 2'sd0);
            case (state)
                RUN: begin
                    if (!wrap) begin
                        phase_o <= phase_o + PHASE_W'(1);
                    end else if (consume == 2'sd1) begin
                        phase_o <= PHASE_W'(1);
                    end else if (consume == -2'sd1) begin
                        phase_o <= LAST;
                        state   <= HOLD;
                    end else begin
                        phase_o <= '0;
                    end
                end
                HOLD: begin
                    phase_o <= '0;
                    state   <= RUN;
                end
                default: begin
                    phase_o <= '0;
                    state   <= RUN;
                end
            endcase
        end
    end

    assign recoveredClk_o = (phase_o < MID);
    assign strobe_o       = (state == RUN) && (phase_o == MID);

endmodule

// File: tb/tb_shift_controlled_oscillator.sv
// Directed cycle-by-cycle check of the oscillator at DIV_N=8, PENDING_W=3.
module tb_shift_controlled_oscillator;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       positiveShift_i = 1'b0;
    logic       negativeShift_i = 1'b0;
    logic [2:0] phase_o;
    logic       recoveredClk_o;
    logic       strobe_o;
    logic       correctionApplied_o;
    logic       overflow_o;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    shift_controlled_oscillator #(
        .DIV_N     (8),
        .PENDING_W (3)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .positiveShift_i     (positiveShift_i),
        .negativeShift_i     (negativeShift_i),
        .phase_o             (phase_o),
        .recoveredClk_o      (recoveredClk_o),
        .strobe_o            (strobe_o),
        .correctionApplied_o (correctionApplied_o),
        .overflow_o          (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Check the current cycle's outputs, then drive this cycle's requests across one edge.
    task automatic cyc(input string name, input int ph, input bit cor, input bit ovf,
                       input bit pos, input bit neg);
        string t;
        t = $sformatf("%s[%0d]", name, cyc_n);
        chk({t, ".phase"}, 32'(phase_o), 32'(ph));
        chk({t, ".rclk"}, 32'(recoveredClk_o), 32'(ph < 4));
        chk({t, ".strobe"}, 32'(strobe_o), 32'(ph == 4));
        chk({t, ".corr"}, 32'(correctionApplied_o), 32'(cor));
        chk({t, ".ovf"}, 32'(overflow_o), 32'(ovf));
        positiveShift_i = pos;
        negativeShift_i = neg;
        @(posedge clk_i);
        #1;
        positiveShift_i = 1'b0;
        negativeShift_i = 1'b0;
        cyc_n++;
    endtask

    task automatic seg(input string name, input int lo, input int hi);
        for (int p = lo; p <= hi; p++) cyc(name, p, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.phase", 32'(phase_o), 32'd0);
        chk("reset.rclk", 32'(recoveredClk_o), 32'd1);
        chk("reset.strobe", 32'(strobe_o), 32'd0);
        chk("reset.corr", 32'(correctionApplied_o), 32'd0);
        chk("reset.ovf", 32'(overflow_o), 32'd0);
        reset_i = 1'b1;

        // Free run: two plain 8-cycle periods.
        seg("free", 0, 7);
        seg("free", 0, 7);

        // One advance: wrap 7->1 gives a 7-cycle period, then back to 8.
        seg("pos", 0, 1);
        cyc("pos", 2, 1'b0, 1'b0, 1'b1, 1'b0);
        seg("pos", 3, 7);
        cyc("pos", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        seg("pos", 2, 7);

        // One retard: phase 7 held an extra cycle, no strobe there.
        seg("neg", 0, 1);
        cyc("neg", 2, 1'b0, 1'b0, 1'b0, 1'b1);
        seg("neg", 3, 7);
        cyc("neg", 7, 1'b1, 1'b0, 1'b0, 1'b0);
        seg("neg", 0, 7);

        // Five advances: saturate at +3, two drops, three short periods.
        for (int p = 0; p <= 3; p++) cyc("sat", p, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("sat", 4, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("sat", 5, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("sat", 6, 7);
        for (int k = 0; k < 3; k++) begin
            cyc("sat", 1, 1'b1, 1'b0, 1'b0, 1'b0);
            seg("sat", 2, 7);
        end
        seg("sat", 0, 7);

        // Simultaneous pair is ignored; a wrap-cycle request hits the next wrap only.
        seg("both", 0, 1);
        cyc("both", 2, 1'b0, 1'b0, 1'b1, 1'b1);
        seg("both", 3, 6);
        cyc("wrap", 7, 1'b0, 1'b0, 1'b1, 1'b0);
        seg("wrap", 0, 7);
        cyc("wrap", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        seg("wrap", 2, 7);

        // Three retards, then reset inside HOLD while pending is -2.
        for (int p = 0; p <= 2; p++) cyc("hrst", p, 1'b0, 1'b0, 1'b0, 1'b1);
        seg("hrst", 3, 7);
        reset_i = 1'b0;
        cyc("hrst", 7, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_i = 1'b1;
        cyc("hrst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        seg("hrst", 1, 7);
        seg("after", 0, 7);
        seg("after", 0, 7);
        chk("after.end_phase", 32'(phase_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
